// File: rtl/aipp_t_noc_pkg.sv
// Shared defaults, widths and the thermal deflection helper for the AIPP-T NoC router.
package aipp_t_noc_pkg;

  localparam int DATA_WIDTH_DEFAULT = 32;
  localparam int NUM_PORTS_DEFAULT  = 4;
  localparam int MAX_PORTS          = 16;
  localparam int MAX_DEST_W         = 4;

  function automatic int dest_width(input int num_ports);
    return (num_ports > 1) ? $clog2(num_ports) : 1;
  endfunction

  localparam int DEST_W_DEFAULT = dest_width(NUM_PORTS_DEFAULT);

  typedef struct packed {
    logic                  found;
    logic [MAX_DEST_W-1:0] port;
  } cool_port_t;

  // Scans dest, dest+1, ... with wrap-around; num_ports must be a power of two.
  function automatic cool_port_t next_cool_port(input logic [MAX_DEST_W-1:0] dest,
                                                input logic [MAX_PORTS-1:0]  inhibit,
                                                input int                    num_ports);
    cool_port_t            res;
    logic [MAX_DEST_W-1:0] mask;
    logic [MAX_DEST_W-1:0] cand;
    res  = '0;
    mask = MAX_DEST_W'(num_ports - 1);
    for (int k = 0; k < MAX_PORTS; k++) begin
      cand = (dest + MAX_DEST_W'(k)) & mask;
      if ((k < num_ports) && !res.found && !inhibit[cand]) begin
        res.found = 1'b1;
        res.port  = cand;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/aipp_thermal_noc_router_if.sv
// Bundle of flit, handshake and thermal signals between the tile interfaces and the router.
interface aipp_thermal_noc_router_if #(
  parameter int DATA_WIDTH = aipp_t_noc_pkg::DATA_WIDTH_DEFAULT,
  parameter int NUM_PORTS  = aipp_t_noc_pkg::NUM_PORTS_DEFAULT
);
  localparam int DEST_W = aipp_t_noc_pkg::dest_width(NUM_PORTS);

  logic [NUM_PORTS-1:0]            thermal_inhibit;
  logic [NUM_PORTS-1:0]            thermal_ack;
  logic [NUM_PORTS-1:0]            in_valid;
  logic [NUM_PORTS*DATA_WIDTH-1:0] in_data;
  logic [NUM_PORTS*DEST_W-1:0]     in_dest;
  logic [NUM_PORTS-1:0]            in_ready;
  logic [NUM_PORTS-1:0]            out_valid;
  logic [NUM_PORTS*DATA_WIDTH-1:0] out_data;
  logic [NUM_PORTS-1:0]            out_ready;

  modport master (
    output thermal_inhibit, in_valid, in_data, in_dest, out_ready,
    input  thermal_ack, in_ready, out_valid, out_data
  );

  modport slave (
    input  thermal_inhibit, in_valid, in_data, in_dest, out_ready,
    output thermal_ack, in_ready, out_valid, out_data
  );

endinterface

// File: rtl/aipp_t_noc_rr_arbiter.sv
// Round-robin arbiter with one-hot grant; the pointer moves past the winner after each grant.
module aipp_t_noc_rr_arbiter #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [N-1:0] req,
  output logic [N-1:0] grant
);
  localparam int W = (N > 1) ? $clog2(N) : 1;

  logic [W-1:0] ptr;
  logic [W-1:0] winner;
  logic [W-1:0] idx;
  logic         hit;

  always_comb begin
    grant  = '0;
    winner = '0;
    idx    = '0;
    hit    = 1'b0;
    if (en) begin
      for (int k = 0; k < N; k++) begin
        idx = ptr + W'(k);
        if (!hit && req[idx]) begin
          hit        = 1'b1;
          winner     = idx;
          grant[idx] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (hit) begin
      ptr <= winner + W'(1);
    end
  end

endmodule

// File: rtl/aipp_thermal_noc_router.sv
// Single-stage thermally aware crossbar; AIPP_T_NOC_DEFLECT_EN enables wrap-around deflection
// away from inhibited outputs, otherwise inhibited destinations simply stall.
module aipp_thermal_noc_router
  import aipp_t_noc_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT,
  parameter int NUM_PORTS  = NUM_PORTS_DEFAULT
) (
  input logic                      clk,
  input logic                      rst,
  aipp_thermal_noc_router_if.slave bus
);
  localparam int DEST_W = dest_width(NUM_PORTS);

  logic [NUM_PORTS-1:0]            tgt_found;
  logic [DEST_W-1:0]               tgt [NUM_PORTS];
  logic [NUM_PORTS-1:0]            out_free;
  logic [NUM_PORTS-1:0]            grant [NUM_PORTS];
  logic [DATA_WIDTH-1:0]           mux_data [NUM_PORTS];
  logic [NUM_PORTS-1:0]            ready;
  logic [NUM_PORTS-1:0]            valid_q;
  logic [NUM_PORTS*DATA_WIDTH-1:0] data_q;

  assign bus.thermal_ack = bus.thermal_inhibit;
  assign bus.in_ready    = ready;
  assign bus.out_valid   = valid_q;
  assign bus.out_data    = data_q;

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_tgt
    logic [DEST_W-1:0] dest;
    assign dest = bus.in_dest[i*DEST_W +: DEST_W];
`ifdef AIPP_T_NOC_DEFLECT_EN
    cool_port_t cool;
    assign cool         = next_cool_port(MAX_DEST_W'(dest), MAX_PORTS'(bus.thermal_inhibit), NUM_PORTS);
    assign tgt_found[i] = cool.found;
    assign tgt[i]       = DEST_W'(cool.port);
`else
    assign tgt_found[i] = !bus.thermal_inhibit[dest];
    assign tgt[i]       = dest;
`endif
  end

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_out
    logic [NUM_PORTS-1:0] req_p;
    logic [NUM_PORTS-1:0] grant_p;

    assign out_free[p] = !valid_q[p] || bus.out_ready[p];

    always_comb begin
      req_p = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
        req_p[i] = bus.in_valid[i] && tgt_found[i] && (tgt[i] == DEST_W'(p));
      end
    end

    // Arbitration is suppressed while the output is occupied or the router is in reset.
    aipp_t_noc_rr_arbiter #(.N(NUM_PORTS)) u_arb (
      .clk   (clk),
      .rst   (rst),
      .en    (out_free[p] && !rst),
      .req   (req_p),
      .grant (grant_p)
    );

    assign grant[p] = grant_p;
  end

  always_comb begin
    ready = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      mux_data[p] = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (grant[p][i]) begin
          ready[i]    = 1'b1;
          mux_data[p] = mux_data[p] | bus.in_data[i*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
  end

  // Stale data is kept when an output drains; only valid clears.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      data_q  <= '0;
    end else begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (|grant[p]) begin
          valid_q[p]                         <= 1'b1;
          data_q[p*DATA_WIDTH +: DATA_WIDTH] <= mux_data[p];
        end else if (out_free[p]) begin
          valid_q[p] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_aipp_thermal_noc_router.sv
// Directed bench for aipp_thermal_noc_router; expectations adapt to AIPP_T_NOC_DEFLECT_EN.
module tb_aipp_thermal_noc_router;
  localparam int DW = 32;
  localparam int NP = 4;
`ifdef AIPP_T_NOC_DEFLECT_EN
  localparam bit DEFLECT = 1'b1;
`else
  localparam bit DEFLECT = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  aipp_thermal_noc_router_if #(.DATA_WIDTH(DW), .NUM_PORTS(NP)) bus ();

  aipp_thermal_noc_router #(.DATA_WIDTH(DW), .NUM_PORTS(NP)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] valid, input logic [7:0] dest,
                               input logic [127:0] data, input logic [3:0] inhib,
                               input logic [3:0] oready);
    bus.in_valid        = valid;
    bus.in_dest         = dest;
    bus.in_data         = data;
    bus.thermal_inhibit = inhib;
    bus.out_ready       = oready;
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] outSlice(input int p);
    return bus.out_data[p*DW +: DW];
  endfunction

  initial begin
    $display("[TB] start, deflection=%0d", DEFLECT);

    rst = 1'b1;
    applyStimulus(4'b0001, 8'h02, {96'h0, 32'h5555AAAA}, 4'b1010, 4'b1111);
    step();
    step();
    checkOutput("rst_in_ready", bus.in_ready, 4'b0000);
    checkOutput("rst_out_valid", bus.out_valid, 4'b0000);
    checkOutput("rst_out_data", bus.out_data, 128'h0);
    checkOutput("rst_ack", bus.thermal_ack, 4'b1010);

    rst = 1'b0;
    applyStimulus(4'b0000, 8'h00, 128'h0, 4'b0000, 4'b1111);
    step();
    checkOutput("idle_out_valid", bus.out_valid, 4'b0000);

    // standard route in0 -> out2
    applyStimulus(4'b0001, 8'h02, {96'h0, 32'hDEADBEEF}, 4'b0000, 4'b1111);
    checkOutput("route_ready", bus.in_ready, 4'b0001);
    step();
    checkOutput("route_valid", bus.out_valid, 4'b0100);
    checkOutput("route_data", outSlice(2), 32'hDEADBEEF);
    applyStimulus(4'b0000, 8'h00, 128'h0, 4'b0000, 4'b1111);
    step();
    checkOutput("route_drain", bus.out_valid, 4'b0000);

    // contention on out1: in0 first, then in1, then in0 again
    applyStimulus(4'b0011, 8'b0000_0101, {64'h0, 32'hA1111111, 32'hA0000000}, 4'b0000, 4'b1111);
    checkOutput("cont1_ready", bus.in_ready, 4'b0001);
    step();
    checkOutput("cont1_valid", bus.out_valid, 4'b0010);
    checkOutput("cont1_data", outSlice(1), 32'hA0000000);
    applyStimulus(4'b0011, 8'b0000_0101, {64'h0, 32'hA1111111, 32'hB0000000}, 4'b0000, 4'b1111);
    checkOutput("cont2_ready", bus.in_ready, 4'b0010);
    step();
    checkOutput("cont2_data", outSlice(1), 32'hA1111111);
    applyStimulus(4'b0011, 8'b0000_0101, {64'h0, 32'hC1111111, 32'hB0000000}, 4'b0000, 4'b1111);
    checkOutput("cont3_ready", bus.in_ready, 4'b0001);
    step();
    checkOutput("cont3_data", outSlice(1), 32'hB0000000);
    applyStimulus(4'b0000, 8'h00, 128'h0, 4'b0000, 4'b1111);
    step();
    checkOutput("cont_drain", bus.out_valid, 4'b0000);

    // single deflection 2 -> 3
    applyStimulus(4'b0001, 8'h02, {96'h0, 32'hCAFEBABE}, 4'b0100, 4'b1111);
    checkOutput("defl_ack", bus.thermal_ack, 4'b0100);
    checkOutput("defl_ready", bus.in_ready, DEFLECT ? 4'b0001 : 4'b0000);
    step();
    checkOutput("defl_valid", bus.out_valid, DEFLECT ? 4'b1000 : 4'b0000);
    checkOutput("defl_data", outSlice(3), DEFLECT ? 32'hCAFEBABE : 32'h0);
    applyStimulus(4'b0000, 8'h00, 128'h0, 4'b0000, 4'b1111);
    step();

    // wrap-around 3 -> 0 -> 1
    applyStimulus(4'b0001, 8'h03, {96'h0, 32'h11112222}, 4'b1001, 4'b1111);
    checkOutput("wrap_ready", bus.in_ready, DEFLECT ? 4'b0001 : 4'b0000);
    step();
    checkOutput("wrap_valid", bus.out_valid, DEFLECT ? 4'b0010 : 4'b0000);
    checkOutput("wrap_data", outSlice(1), DEFLECT ? 32'h11112222 : 32'hB0000000);
    applyStimulus(4'b0000, 8'h00, 128'h0, 4'b0000, 4'b1111);
    step();

    // all outputs hot
    applyStimulus(4'b0001, 8'h00, {96'h0, 32'h33334444}, 4'b1111, 4'b1111);
    checkOutput("hot_ready", bus.in_ready, 4'b0000);
    checkOutput("hot_ack", bus.thermal_ack, 4'b1111);
    step();
    checkOutput("hot_valid", bus.out_valid, 4'b0000);

    // backpressure on out2
    applyStimulus(4'b0001, 8'h02, {96'h0, 32'h0BAD0002}, 4'b0000, 4'b1011);
    checkOutput("bp_first_ready", bus.in_ready, 4'b0001);
    step();
    checkOutput("bp_first_valid", bus.out_valid, 4'b0100);
    checkOutput("bp_first_data", outSlice(2), 32'h0BAD0002);
    applyStimulus(4'b0010, 8'b0000_1000, {64'h0, 32'h1EE10001, 32'h0}, 4'b0000, 4'b1011);
    checkOutput("bp_hold_ready", bus.in_ready, 4'b0000);
    step();
    checkOutput("bp_hold_valid", bus.out_valid, 4'b0100);
    checkOutput("bp_hold_data", outSlice(2), 32'h0BAD0002);
    applyStimulus(4'b0010, 8'b0000_1000, {64'h0, 32'h1EE10001, 32'h0}, 4'b0000, 4'b1111);
    checkOutput("bp_release_ready", bus.in_ready, 4'b0010);
    step();
    checkOutput("bp_release_valid", bus.out_valid, 4'b0100);
    checkOutput("bp_release_data", outSlice(2), 32'h1EE10001);

    // reset with out1 and out2 occupied
    applyStimulus(4'b0001, 8'h01, {96'h0, 32'h12345678}, 4'b0000, 4'b1001);
    checkOutput("pre_rst_ready", bus.in_ready, 4'b0001);
    step();
    checkOutput("pre_rst_valid", bus.out_valid, 4'b0110);
    checkOutput("pre_rst_data1", outSlice(1), 32'h12345678);
    rst = 1'b1;
    applyStimulus(4'b0001, 8'h01, {96'h0, 32'h00000077}, 4'b0101, 4'b0000);
    checkOutput("mid_rst_ready", bus.in_ready, 4'b0000);
    checkOutput("mid_rst_ack", bus.thermal_ack, 4'b0101);
    step();
    checkOutput("mid_rst_valid", bus.out_valid, 4'b0000);
    checkOutput("mid_rst_data", bus.out_data, 128'h0);
    applyStimulus(4'b0001, 8'h01, {96'h0, 32'h00000077}, 4'b1010, 4'b0000);
    checkOutput("mid_rst_ack2", bus.thermal_ack, 4'b1010);

    // arbiter pointer restarts at 0 after reset
    rst = 1'b0;
    applyStimulus(4'b0011, 8'b0000_0101, {64'h0, 32'hD1111111, 32'hD0000000}, 4'b0000, 4'b1111);
    checkOutput("post_rst_ready", bus.in_ready, 4'b0001);
    step();
    checkOutput("post_rst_data", outSlice(1), 32'hD0000000);
    applyStimulus(4'b0000, 8'h00, 128'h0, 4'b0000, 4'b1111);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
